// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kyber_pkg
//  Purpose  : Shared Kyber arithmetic constants and coefficient/product types
//             used by the modular-multiply pipeline and its helpers.
//  Contents : KYBER_Q, KYBER_W, BARRETT_K, BARRETT_M, coeff_t, prod_t
//  Revision : 1.0 - initial release
// ============================================================================
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int KYBER_W   = 12;
  localparam int BARRETT_K = 24;
  localparam int BARRETT_M = 5039;   // floor(2^24 / 3329)

  typedef logic [KYBER_W-1:0]   coeff_t;
  typedef logic [BARRETT_K-1:0] prod_t;

endpackage
`default_nettype wire

// File: rtl/mulred_k_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : mulred_k_pipe_if
//  Purpose  : Valid/ready streaming bus for the Kyber modular multiplier.
//             Input side carries operand pairs plus a last flag, output side
//             carries the reduced residue plus the matching last flag.
//  Modports : slave  - the multiplier (consumes operands, produces results)
//             master - the environment (produces operands, consumes results)
//  Options  : MULRED_K_RANGE_CHK_EN adds range_err_o alongside the result.
//  Revision : 1.0 - initial release
// ============================================================================
interface mulred_k_pipe_if;
  import kyber_pkg::*;

  coeff_t a_i;
  coeff_t b_i;
  logic   last_i;
  logic   valid_i;
  logic   ready_o;
  coeff_t result_o;
  logic   last_o;
  logic   valid_o;
  logic   ready_i;

`ifdef MULRED_K_RANGE_CHK_EN
  logic   range_err_o;

  modport slave (
    input  a_i, b_i, last_i, valid_i, ready_i,
    output ready_o, result_o, last_o, valid_o, range_err_o
  );
  modport master (
    output a_i, b_i, last_i, valid_i, ready_i,
    input  ready_o, result_o, last_o, valid_o, range_err_o
  );
`else
  modport slave (
    input  a_i, b_i, last_i, valid_i, ready_i,
    output ready_o, result_o, last_o, valid_o
  );
  modport master (
    output a_i, b_i, last_i, valid_i, ready_i,
    input  ready_o, result_o, last_o, valid_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/csub_k.sv
`default_nettype none
// ============================================================================
//  Module   : csub_k
//  Purpose  : Combinational conditional subtraction bringing a value in
//             [0, 2Q) into canonical range [0, Q). Shared with add/sub
//             butterflies.
//  Ports    : diff - W+1 bit input value
//             res  - W bit canonical residue
//  Revision : 1.0 - initial release
// ============================================================================
module csub_k
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q,
  parameter int W = KYBER_W
) (
  input  logic [W:0]   diff,
  output logic [W-1:0] res
);

  localparam logic [W:0] c_q = (W+1)'(Q);

  logic [W:0] w_sel;

  assign w_sel = (diff >= c_q) ? (diff - c_q) : diff;
  // Top bit is zero for any input below 2Q.
  assign res   = W'(w_sel);

endmodule
`default_nettype wire

// File: rtl/mulred_k_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mulred_k_pipe
//  Purpose  : Three-stage streaming modular multiplier for Kyber. Computes
//             (a*b) mod Q with Barrett reduction at one result per cycle,
//             under valid/ready backpressure with bubble collapse.
//               S1: p = a*b
//               S2: p, t = (p*M) >> K
//               S3: csub(p - t*Q)
//  Ports    : clk_i   - clock
//             rst_n_i - asynchronous active-low reset
//             bus     - mulred_k_pipe_if.slave (operands in, residues out)
//  Options  : MULRED_K_RANGE_CHK_EN - carries an out-of-range operand flag
//             through the pipe and presents it on bus.range_err_o.
//  Revision : 1.0 - initial release
// ============================================================================
module mulred_k_pipe
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q,
  parameter int W = KYBER_W,
  parameter int K = BARRETT_K,
  parameter int M = BARRETT_M
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  mulred_k_pipe_if.slave   bus
);

  localparam logic [K-1:0] c_m = K'(M);
  localparam logic [K-1:0] c_q = K'(Q);

  logic         r_v1, r_v2, r_v3;
  logic [K-1:0] r_s1_p, r_s2_p;
  logic [W-1:0] r_s2_t, r_s3_res;
  logic         r_s1_last, r_s2_last, r_s3_last;

  logic           w_adv1, w_adv2, w_adv3;
  logic [K-1:0]   w_p;
  logic [2*K-1:0] w_pm;
  logic [W-1:0]   w_t;
  logic [K-1:0]   w_r_full;
  logic [W:0]     w_r;
  logic [W-1:0]   w_res;

  // Advance evaluated from the output backwards so an empty stage always
  // accepts, even while a later stage is stalled.
  assign w_adv3 = !r_v3 || bus.ready_i;
  assign w_adv2 = !r_v2 || w_adv3;
  assign w_adv1 = !r_v1 || w_adv2;

  assign w_p      = {{(K-W){1'b0}}, bus.a_i} * {{(K-W){1'b0}}, bus.b_i};
  assign w_pm     = {{K{1'b0}}, r_s1_p} * {{K{1'b0}}, c_m};
  assign w_t      = W'(w_pm >> K);
  // Barrett underestimates the quotient by at most one, so the remainder
  // fits in W+1 bits and needs a single conditional subtraction.
  assign w_r_full = r_s2_p - ({{(K-W){1'b0}}, r_s2_t} * c_q);
  assign w_r      = (W+1)'(w_r_full);

  csub_k #(.Q(Q), .W(W)) u_csub (
    .diff (w_r),
    .res  (w_res)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_s1_p    <= '0;
      r_s2_p    <= '0;
      r_s2_t    <= '0;
      r_s3_res  <= '0;
      r_s1_last <= 1'b0;
      r_s2_last <= 1'b0;
      r_s3_last <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1      <= bus.valid_i;
        r_s1_p    <= w_p;
        r_s1_last <= bus.last_i;
      end
      if (w_adv2) begin
        r_v2      <= r_v1;
        r_s2_p    <= r_s1_p;
        r_s2_t    <= w_t;
        r_s2_last <= r_s1_last;
      end
      if (w_adv3) begin
        r_v3      <= r_v2;
        r_s3_res  <= w_res;
        r_s3_last <= r_s2_last;
      end
    end
  end

  assign bus.ready_o  = w_adv1;
  assign bus.valid_o  = r_v3;
  assign bus.result_o = r_s3_res;
  assign bus.last_o   = r_s3_last;

`ifdef MULRED_K_RANGE_CHK_EN
  localparam logic [W-1:0] c_q_w = W'(Q);

  logic r_s1_err, r_s2_err, r_s3_err;
  logic w_err_in;

  assign w_err_in = (bus.a_i >= c_q_w) || (bus.b_i >= c_q_w);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1_err <= 1'b0;
      r_s2_err <= 1'b0;
      r_s3_err <= 1'b0;
    end else begin
      if (w_adv1) r_s1_err <= w_err_in;
      if (w_adv2) r_s2_err <= r_s1_err;
      if (w_adv3) r_s3_err <= r_s2_err;
    end
  end

  assign bus.range_err_o = r_s3_err;
`endif

endmodule
`default_nettype wire
